// File: rtl/uart_dbg_pkg.sv
// Shared types, ASCII constants and hex helpers for the UART command controller.
package uart_dbg_pkg;

    typedef enum logic [3:0] {
        S_IDLE,
        S_ADDR_HI,
        S_ADDR_LO,
        S_DATA_HI,
        S_DATA_LO,
        S_EXEC_WR,
        S_EXEC_RD,
        S_RD_WAIT,
        S_TX_HI,
        S_TX_LO,
        S_TX_CR,
        S_TX_LF,
        S_TX_ERR
    } state_e;

    localparam logic [7:0] ASCII_CR   = 8'h0D;
    localparam logic [7:0] ASCII_LF   = 8'h0A;
    localparam logic [7:0] ASCII_QM   = 8'h3F;
    localparam logic [7:0] ASCII_W_LC = 8'h77;
    localparam logic [7:0] ASCII_W_UC = 8'h57;
    localparam logic [7:0] ASCII_R_LC = 8'h72;
    localparam logic [7:0] ASCII_R_UC = 8'h52;

    function automatic logic is_hex(input logic [7:0] c);
        return ((c >= 8'h30) && (c <= 8'h39)) ||
               ((c >= 8'h41) && (c <= 8'h46)) ||
               ((c >= 8'h61) && (c <= 8'h66));
    endfunction

    // Letters A-F/a-f all have low nibble 1..6, so add 9 to land on 10..15.
    function automatic logic [3:0] hex_to_nibble(input logic [7:0] c);
        return (c >= 8'h41) ? (c[3:0] + 4'd9) : c[3:0];
    endfunction

    function automatic logic [7:0] nibble_to_hex(input logic [3:0] n);
        return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
    endfunction

endpackage

// File: rtl/uart_cmd_ctrl_if.sv
// Byte stream, TX handshake and register bus between the controller and its neighbours.
interface uart_cmd_ctrl_if;
    logic [7:0] i_rx_data;
    logic       i_rx_valid;
    logic [7:0] o_tx_data;
    logic       o_tx_start;
    logic       i_tx_busy;
    logic [7:0] o_reg_addr;
    logic [7:0] o_reg_wdata;
    logic       o_reg_we;
    logic       o_reg_re;
    logic [7:0] i_reg_rdata;
    logic       o_busy;
    logic       o_err;

    modport master (
        output i_rx_data, i_rx_valid, i_tx_busy, i_reg_rdata,
        input  o_tx_data, o_tx_start, o_reg_addr, o_reg_wdata,
               o_reg_we, o_reg_re, o_busy, o_err
    );

    modport slave (
        input  i_rx_data, i_rx_valid, i_tx_busy, i_reg_rdata,
        output o_tx_data, o_tx_start, o_reg_addr, o_reg_wdata,
               o_reg_we, o_reg_re, o_busy, o_err
    );
endinterface

// File: rtl/uart_cmd_ctrl_timeout_cnt.sv
// Inter-byte idle counter: reloads on each accepted byte, counts down while enabled.
module cmd_timeout_cnt #(
    parameter int unsigned    W        = 32,
    parameter logic [W-1:0]   LOAD_VAL = '1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    input  logic en,
    output logic expired
);
    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load)
            cnt_d = LOAD_VAL;
        else if (en && (cnt_q != '0))
            cnt_d = cnt_q - 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

    assign expired = en && (cnt_q == '0);
endmodule

// File: rtl/uart_cmd_ctrl.sv
// ASCII command parser: "wAADD" writes a register, "rAA" reads one and echoes it as hex + CRLF.
module uart_cmd_ctrl
    import uart_dbg_pkg::*;
#(
    parameter int unsigned CLK_FREQ      = 50000000,
    parameter int unsigned BAUD_RATE     = 115200,
    parameter int unsigned TIMEOUT_BYTES = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    uart_cmd_ctrl_if.slave bus
);
    localparam int unsigned  TO_W    = 32;
    localparam logic [TO_W-1:0] TO_LOAD =
        TO_W'((64'(TIMEOUT_BYTES) * 64'd10 * 64'(CLK_FREQ)) / 64'(BAUD_RATE));

    state_e     state_q, state_d;
    logic       is_wr_q, is_wr_d;
    logic [7:0] addr_q, addr_d;
    logic [7:0] wdata_q, wdata_d;
    logic [7:0] rdata_q, rdata_d;
    logic [7:0] tx_data_q, tx_data_d;
    logic       tx_start_q, tx_start_d;
    logic       we_q, we_d;
    logic       re_q, re_d;
    logic       err_q, err_d;
    logic       busy_q, busy_d;

    logic       to_load, to_en, to_expired;
    logic       tx_ok, rx_hex;
    logic [3:0] rx_nib;

    cmd_timeout_cnt #(.W(TO_W), .LOAD_VAL(TO_LOAD)) u_timeout (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (to_load),
        .en      (to_en),
        .expired (to_expired)
    );

    assign to_en  = state_q inside {S_ADDR_HI, S_ADDR_LO, S_DATA_HI, S_DATA_LO};
    // Back-to-back starts are blocked because TX only raises busy a cycle later.
    assign tx_ok  = !bus.i_tx_busy && !tx_start_q;
    assign rx_hex = is_hex(bus.i_rx_data);
    assign rx_nib = hex_to_nibble(bus.i_rx_data);

    always_comb begin
        state_d    = state_q;
        is_wr_d    = is_wr_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        rdata_d    = rdata_q;
        tx_data_d  = tx_data_q;
        tx_start_d = 1'b0;
        we_d       = 1'b0;
        re_d       = 1'b0;
        err_d      = 1'b0;
        to_load    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (bus.i_rx_valid) begin
                    if (bus.i_rx_data == ASCII_W_LC || bus.i_rx_data == ASCII_W_UC) begin
                        state_d = S_ADDR_HI;
                        is_wr_d = 1'b1;
                        to_load = 1'b1;
                    end else if (bus.i_rx_data == ASCII_R_LC || bus.i_rx_data == ASCII_R_UC) begin
                        state_d = S_ADDR_HI;
                        is_wr_d = 1'b0;
                        to_load = 1'b1;
                    end
                end
            end
            S_ADDR_HI, S_ADDR_LO, S_DATA_HI, S_DATA_LO: begin
                // Expiry beats a byte arriving on the same cycle.
                if (to_expired) begin
                    state_d = S_IDLE;
                    err_d   = 1'b1;
                end else if (bus.i_rx_valid) begin
                    if (!rx_hex) begin
                        state_d = S_TX_ERR;
                        err_d   = 1'b1;
                    end else begin
                        to_load = 1'b1;
                        case (state_q)
                            S_ADDR_HI: begin
                                addr_d[7:4] = rx_nib;
                                state_d     = S_ADDR_LO;
                            end
                            S_ADDR_LO: begin
                                addr_d[3:0] = rx_nib;
                                state_d     = is_wr_q ? S_DATA_HI : S_EXEC_RD;
                                re_d        = !is_wr_q;
                            end
                            S_DATA_HI: begin
                                wdata_d[7:4] = rx_nib;
                                state_d      = S_DATA_LO;
                            end
                            default: begin
                                wdata_d[3:0] = rx_nib;
                                state_d      = S_EXEC_WR;
                                we_d         = 1'b1;
                            end
                        endcase
                    end
                end
            end
            S_EXEC_WR: state_d = S_IDLE;
            S_EXEC_RD: state_d = S_RD_WAIT;
            S_RD_WAIT: begin
                rdata_d = bus.i_reg_rdata;
                state_d = S_TX_HI;
            end
            S_TX_HI, S_TX_LO, S_TX_CR, S_TX_LF, S_TX_ERR: begin
                if (tx_ok) begin
                    tx_start_d = 1'b1;
                    case (state_q)
                        S_TX_HI:  begin tx_data_d = nibble_to_hex(rdata_q[7:4]); state_d = S_TX_LO; end
                        S_TX_LO:  begin tx_data_d = nibble_to_hex(rdata_q[3:0]); state_d = S_TX_CR; end
                        S_TX_ERR: begin tx_data_d = ASCII_QM;                    state_d = S_TX_CR; end
                        S_TX_CR:  begin tx_data_d = ASCII_CR;                    state_d = S_TX_LF; end
                        default:  begin tx_data_d = ASCII_LF;                    state_d = S_IDLE;  end
                    endcase
                end
            end
            default: state_d = S_IDLE;
        endcase

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            is_wr_q    <= 1'b0;
            addr_q     <= 8'h00;
            wdata_q    <= 8'h00;
            rdata_q    <= 8'h00;
            tx_data_q  <= 8'h00;
            tx_start_q <= 1'b0;
            we_q       <= 1'b0;
            re_q       <= 1'b0;
            err_q      <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            is_wr_q    <= is_wr_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            rdata_q    <= rdata_d;
            tx_data_q  <= tx_data_d;
            tx_start_q <= tx_start_d;
            we_q       <= we_d;
            re_q       <= re_d;
            err_q      <= err_d;
            busy_q     <= busy_d;
        end
    end

    assign bus.o_tx_data   = tx_data_q;
    assign bus.o_tx_start  = tx_start_q;
    assign bus.o_reg_addr  = addr_q;
    assign bus.o_reg_wdata = wdata_q;
    assign bus.o_reg_we    = we_q;
    assign bus.o_reg_re    = re_q;
    assign bus.o_busy      = busy_q;
    assign bus.o_err       = err_q;
endmodule

// File: doc/uart_cmd_ctrl.md
UART_CMD_CTRL -- requirements
Module: uart_cmd_ctrl

Interface
REQ-001 Parameter: CLK_FREQ, default 50000000, system clock frequency in Hz.
REQ-002 Parameter: BAUD_RATE, default 115200, UART bit rate.
REQ-003 Parameter: TIMEOUT_BYTES, default 4, inter-byte idle limit in UART byte times.
REQ-004 The block SHALL use one clock and a synchronous, active-low reset, with ports as follows.
REQ-005 clk  in  1  system clock, all logic on rising edge.
REQ-006 rst_n  in  1  synchronous active-low reset.
REQ-007 i_rx_data  in  8  received byte from UART RX.
REQ-008 i_rx_valid  in  1  one-cycle strobe, i_rx_data valid.
REQ-009 o_tx_data  out  8  byte to transmit.
REQ-010 o_tx_start  out  1  one-cycle start strobe to UART TX.
REQ-011 i_tx_busy  in  1  UART TX busy, high from the cycle after o_tx_start until the stop bit ends.
REQ-012 o_reg_addr  out  8  register address.
REQ-013 o_reg_wdata  out  8  register write data.
REQ-014 o_reg_we  out  1  one-cycle write strobe.
REQ-015 o_reg_re  out  1  one-cycle read strobe.
REQ-016 i_reg_rdata  in  8  read data, valid exactly 1 cycle after o_reg_re.
REQ-017 o_busy  out  1  high in any state other than IDLE.
REQ-018 o_err  out  1  one-cycle pulse on parse error or timeout.

Function
REQ-019 Command grammar: 'w'|'W' + 2 hex address chars + 2 hex data chars = write; 'r'|'R' + 2 hex address chars = read; hex digits are 0-9, A-F, a-f, most significant nibble first.
REQ-020 FSM states: IDLE, ADDR_HI, ADDR_LO, DATA_HI, DATA_LO, EXEC_WR, EXEC_RD, RD_WAIT, TX_HI, TX_LO, TX_CR, TX_LF, TX_ERR.
REQ-021 IDLE: 'w'/'W' -> ADDR_HI with write flag; 'r'/'R' -> ADDR_HI with read flag; any other byte ignored silently, no o_err.
REQ-022 ADDR_HI -> ADDR_LO -> (write: DATA_HI -> DATA_LO -> EXEC_WR; read: EXEC_RD), each step advancing on a valid hex byte.
REQ-023 A non-hex byte in ADDR_HI/ADDR_LO/DATA_HI/DATA_LO SHALL discard the command, pulse o_err and go to TX_ERR.
REQ-024 EXEC_WR: assert o_reg_we for exactly 1 cycle with the assembled address/data, then return to IDLE; writes produce no TX response.
REQ-025 EXEC_RD: assert o_reg_re for 1 cycle; RD_WAIT captures i_reg_rdata on the following cycle.
REQ-026 Read response: four bytes sent in order TX_HI, TX_LO, TX_CR, TX_LF = uppercase ASCII hex high nibble, low nibble, 0x0D, 0x0A; then IDLE.
REQ-027 TX_ERR: send '?' (0x3F), then continue through TX_CR and TX_LF.
REQ-028 TX handshake: o_tx_start SHALL pulse only when i_tx_busy=0 and no o_tx_start occurred on the previous cycle; the state advances on the pulse; o_tx_data is held stable from the pulse until i_tx_busy falls.
REQ-029 Timeout: a counter loads TIMEOUT_BYTES*10*CLK_FREQ/BAUD_RATE (integer, at least 24 bits) on each accepted byte in ADDR_HI..DATA_LO and decrements each cycle; reaching 0 SHALL discard the command, pulse o_err and return to IDLE with no TX.
REQ-030 i_rx_valid in any EXEC/RD_WAIT/TX state SHALL be dropped without affecting the FSM.
REQ-031 i_rx_valid coinciding with the timeout expiry cycle: timeout wins and the byte is dropped.
REQ-032 o_reg_we and o_reg_re SHALL never both be high, and neither SHALL be high outside EXEC_WR/EXEC_RD.

Reset
REQ-033 While rst_n=0 at a clk edge: FSM=IDLE; all outputs 0 except o_tx_data=0x00; timeout counter, address, data and read latch cleared.
REQ-034 Reset asserted mid-command or mid-response SHALL abort without completing any pending write; no further o_tx_start is issued after reset.

Structure
REQ-035 Shared package uart_dbg_pkg holds the FSM state enum, ASCII constants (CR, LF, '?', 'w', 'r') and the hex_to_nibble/nibble_to_hex functions.
REQ-036 One sub-module, cmd_timeout_cnt (load/decrement/expire), is instantiated; everything else is in uart_cmd_ctrl.

Verification
REQ-037 Bytes "w01AA" -> one o_reg_we pulse with addr=0x01, wdata=0xAA; no o_tx_start.
REQ-038 "w01AA" then "r01" with rdata=0xAA -> o_reg_re addr=0x01; TX bytes 0x41, 0x41, 0x0D, 0x0A, each started only when i_tx_busy=0.
REQ-039 "r0G" -> o_err pulse, TX 0x3F, 0x0D, 0x0A, no o_reg_re.
REQ-040 "w1" then idle past the timeout -> o_err pulse, IDLE, no TX; a following "r1f" reads addr=0x1F.
REQ-041 Bytes injected during the read response, with i_tx_busy held high for 100 cycles per byte -> bytes ignored, response unchanged, o_busy high throughout.
REQ-042 rst_n=0 for 1 cycle after "w01A" -> no o_reg_we; a following "w0255" writes addr=0x02, data=0x55.
